// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: sums WIDTH-bit operands CHUNK bits per clock with a registered carry.
// Optional subtract mode (Sub port) is enabled by defining CHUNKED_SERIAL_ADDER_SUB_EN.
module chunked_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned CW    = CHUNK + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("chunked_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_d, out_valid_d, cout_d, overflow_d;
  logic [WIDTH-1:0] sum_d;

  // Operand conditioning at accept time: subtraction is A + ~B + ~Cin.
  logic [WIDTH-1:0] b_in_c;
  logic             cin_in_c;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  assign b_in_c   = Sub ? ~B : B;
  assign cin_in_c = Sub ? ~Cin : Cin;
`else
  assign b_in_c   = B;
  assign cin_in_c = Cin;
`endif

  // One ripple stage over the low chunk of the operand shift registers.
  logic [CW-1:0]    chunk_full_c;
  logic [CHUNK-1:0] chunk_sum_c;
  logic             chunk_cout_c;
  logic             msb_cin_c;
  logic             last_c;

  assign chunk_full_c = CW'(a_q[CHUNK-1:0]) + CW'(b_q[CHUNK-1:0]) + CW'(carry_q);
  assign chunk_sum_c  = chunk_full_c[CHUNK-1:0];
  assign chunk_cout_c = chunk_full_c[CHUNK];
  // Carry into the chunk MSB recovered from its sum bit; used for overflow on the last chunk.
  assign msb_cin_c    = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum_c[CHUNK-1];
  assign last_c       = (cnt_q == CNT_W'(N - 1));

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    sum_d       = Sum;
    cout_d      = Cout;
    overflow_d  = Overflow;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = A;
          b_d        = b_in_c;
          carry_d    = cin_in_c;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ADD;
        end
      end
      ADD: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = (res_q >> CHUNK) | (WIDTH'(chunk_sum_c) << (WIDTH - CHUNK));
        carry_d = chunk_cout_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          sum_d       = res_d;
          cout_d      = chunk_cout_c;
          overflow_d  = msb_cin_c ^ chunk_cout_c;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      Sum       <= sum_d;
      Cout      <= cout_d;
      Overflow  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed self-checking bench for chunked_serial_adder (16/4 and 4/4 configurations).
module tb_chunked_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, Sum;
  logic        Cin, Cout, Overflow;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [3:0]  s_A, s_B, s_Sum;
  logic        s_Cin, s_Cout, s_Overflow;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  logic        Sub, s_Sub;
`endif

  int n_cmp;
  int n_bad;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    .Sub(Sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
  );

  chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .A(s_A), .B(s_B), .Cin(s_Cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    .Sub(s_Sub),
`endif
    .out_valid(s_out_valid), .out_ready(s_out_ready), .Sum(s_Sum), .Cout(s_Cout), .Overflow(s_Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one operation, then check latency and the result; leaves the DUT in HOLD.
  task automatic issue_and_wait(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic [15:0] es, input logic ec, input logic eo,
                                input string nm);
    int lat;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s in_ready before accept: got %b want 1", nm, in_ready);
    end
    in_valid = 1'b1; A = a; B = b; Cin = cin;
    @(negedge clk);
    in_valid = 1'b0; A = 16'h5A5A; B = 16'hA5A5; Cin = ~cin;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 4) begin n_bad++; $display("FAIL %s latency: got %0d want 4", nm, lat); end
    n_cmp++;
    if (Sum !== es) begin n_bad++; $display("FAIL %s Sum: got %h want %h", nm, Sum, es); end
    n_cmp++;
    if (Cout !== ec) begin n_bad++; $display("FAIL %s Cout: got %b want %b", nm, Cout, ec); end
    n_cmp++;
    if (Overflow !== eo) begin
      n_bad++; $display("FAIL %s Overflow: got %b want %b", nm, Overflow, eo);
    end
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s handshake: got out_valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Sum !== 16'h0 || Cout !== 1'b0 || Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%b vld=%b sum=%h c=%b o=%b want 1 0 0000 0 0",
               in_ready, out_valid, Sum, Cout, Overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    issue_and_wait(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "add_small");
    handshake("add_small");
    issue_and_wait(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_chain");
    handshake("carry_chain");
  endtask

  task automatic test_overflow();
    issue_and_wait(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    handshake("ovf_pos");
    issue_and_wait(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");
    handshake("ovf_neg");
  endtask

  // Result must hold while the consumer stalls; new operands are ignored.
  task automatic test_backpressure();
    issue_and_wait(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "stall");
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; A = 16'h1111 * 16'(i + 1); B = 16'h0F0F; Cin = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || Sum !== 16'h5556 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got vld=%b sum=%h rdy=%b want 1 5556 0",
                 i, out_valid, Sum, in_ready);
      end
    end
    in_valid = 1'b0;
    handshake("stall");
    n_cmp++;
    if (Sum !== 16'h5556) begin n_bad++; $display("FAIL stall_keep: got %h want 5556", Sum); end
  endtask

  // out_ready already high: handshake on the edge after out_valid rises, then re-issue at once.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    issue_and_wait(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, "b2b_first");
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_release: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
    issue_and_wait(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, "b2b_second");
    handshake("b2b_second");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    in_valid = 1'b1; A = 16'h7000; B = 16'h1000; Cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Sum !== 16'h0 || Cout !== 1'b0 || Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL midop_reset: got rdy=%b vld=%b sum=%h c=%b o=%b want 1 0 0000 0 0",
               in_ready, out_valid, Sum, Cout, Overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midop_aborted: got out_valid=%b want 0", out_valid);
    end
    issue_and_wait(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "after_reset");
    handshake("after_reset");
  endtask

  task automatic test_single_chunk();
    int lat;
    @(negedge clk);
    s_in_valid = 1'b1; s_A = 4'h9; s_B = 4'h6; s_Cin = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = 0;
    while (s_out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 1) begin n_bad++; $display("FAIL n1_latency: got %0d want 1", lat); end
    n_cmp++;
    if (s_Sum !== 4'h0 || s_Cout !== 1'b1 || s_Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL n1_result: got sum=%h c=%b o=%b want 0 1 0", s_Sum, s_Cout, s_Overflow);
    end
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    n_cmp++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL n1_handshake: got vld=%b rdy=%b want 0/1", s_out_valid, s_in_ready);
    end
  endtask

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    Sub = 1'b1;
    issue_and_wait(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0, "sub_pos");
    handshake("sub_pos");
    issue_and_wait(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    handshake("sub_neg");
    Sub = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_A = '0; s_B = '0; s_Cin = 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    Sub = 1'b0; s_Sub = 1'b0;
`endif
    test_reset();
    test_add_basic();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_single_chunk();
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using a CHUNK-bit ripple stage and a registered carry.
- Successor to the team's combinational 4-bit full adder: wider operands, less area, valid/ready handshakes on input and output, and signed-overflow reporting.
- Sits between operand producers and consumers that tolerate multi-cycle latency.

Parameters:
WIDTH, 16, operand and sum width in bits; must be >= 1.
CHUNK, 4, bits added per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails with $error.
(Derived) N = WIDTH/CHUNK, chunk-cycles per operation; counter width $clog2(N+1).

Ports:
clk  in  1  clock, rising-edge active.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands A/B/Cin valid.
in_ready  out  1  block can accept operands; high only in IDLE.
A  in  WIDTH  operand A.
B  in  WIDTH  operand B.
Cin  in  1  carry-in.
out_valid  out  1  result valid; held until accepted.
out_ready  in  1  consumer accepts result.
Sum  out  WIDTH  registered result.
Cout  out  1  carry out of bit WIDTH-1.
Overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0, Overflow=0. Internal shift registers, carry and counter are cleared.
- States: IDLE, ADD, HOLD.
- IDLE: in_ready=1.
  - If in_valid=1 on a rising edge: latch A, B and Cin into operand shift registers, set carry=Cin, count=0, go to ADD.
- ADD: in_ready=0, out_valid=0.
  - Each edge: add the low CHUNK bits of the A and B registers plus carry; shift the chunk sum into the result register from the MSB side; shift the operands right by CHUNK; store the chunk carry-out; count++.
  - On the edge that processes chunk N-1: also capture the carry into bit WIDTH-1. Load Sum, Cout and Overflow from the result, set out_valid=1, go to HOLD.
- HOLD: out_valid=1. Sum, Cout and Overflow are stable.
  - When out_ready=1 on an edge, go to IDLE and clear out_valid. in_ready is high in the following cycle; there is no same-edge re-acceptance.
- Latency:
  - out_valid rises exactly N cycles after the accepting edge.
  - Minimum operation period is N+2 cycles (accept, N adds, handshake).
  - If out_ready is already high when out_valid rises, the handshake completes on the next edge.
- Sum, Cout and Overflow change only on entry to HOLD. They keep the last result in IDLE and ADD, and are never exposed as partial values.
- in_valid and operand changes outside IDLE are ignored. Operands are sampled only on the accepting edge.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1). Overflow per signed two's-complement rule.
- N=1 (CHUNK=WIDTH): a single ADD cycle; behaviour is otherwise identical.
- Reset mid-operation (ADD or HOLD): the operation is aborted and the block returns to reset values immediately. The result is lost.

Optional Feature:
- Macro: CHUNKED_SERIAL_ADDER_SUB_EN.
- Defined: adds an input port Sub (1 bit), sampled with the operands on the accepting edge.
  - Sub=1: the block computes A - B - Cin as A + ~B + ~Cin. Cout=1 means no borrow; Overflow uses the signed subtraction rule (the same MSB carry XOR).
  - Sub=0: addition, identical to the base behaviour.
- Undefined: no Sub port; addition only.

Test Plan:
Each case uses WIDTH=16, CHUNK=4, and checks out_valid rising 4 cycles after the accept edge.
1. A=0x0001, B=0x0002, Cin=0 -> Sum=0x0003, Cout=0, Overflow=0.
2. A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Overflow=0 (carry crosses all 4 chunks).
3. A=0x7FFF, B=0x0001, Cin=0 -> Sum=0x8000, Cout=0, Overflow=1. Then A=0x8000, B=0x8000 -> Sum=0x0000, Cout=1, Overflow=1.
4. Hold out_ready=0 for 6 cycles after out_valid and pulse in_valid with new operands -> out_valid stays 1, Sum is stable, in_ready=0, the new operands are ignored. Then raise out_ready -> IDLE next edge, in_ready=1.
5. Assert rst_n=0 during the 2nd ADD cycle -> all outputs go to reset values, in_ready=1. Then A=0xFFFF, B=0xFFFF, Cin=1 -> Sum=0xFFFF, Cout=1, Overflow=0. Repeat with WIDTH=4, CHUNK=4: A=0x9, B=0x6, Cin=1 -> Sum=0x0, Cout=1, 1-cycle latency.
6. With CHUNKED_SERIAL_ADDER_SUB_EN: Sub=1, A=0x0005, B=0x0003, Cin=0 -> Sum=0x0002, Cout=1. Then Sub=1, A=0x0003, B=0x0005, Cin=0 -> Sum=0xFFFE, Cout=0, Overflow=0.
